// File: rtl/line_score_bcd_counter.sv
// rtl/line_score_bcd_counter.sv - line-clear points to saturating two-digit BCD score
// Adds one point per clock in ADD, handshaking line-clear events from the playfield logic.
module line_score_bcd_counter #(
    parameter int PTS_1     = 1,
    parameter int PTS_2     = 3,
    parameter int PTS_3     = 5,
    parameter int PTS_4     = 8,
    parameter int MAX_SCORE = 99
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       restart_i,
    input  logic       clear_valid_i,
    input  logic [2:0] clear_count_i,
    output logic       clear_ready_o,
    output logic [9:0] score_o,
    output logic       add_done_o,
    output logic       saturated_o,
    output logic       bad_count_o
);

    typedef enum logic {IDLE, ADD} state_t;

    localparam logic [3:0] MAX_TENS = 4'(MAX_SCORE / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_SCORE % 10);

    state_t     state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       add_done_q, add_done_d;
    logic       bad_count_q, bad_count_d;
    logic       saturated_q, saturated_d;
    logic [3:0] pts;
    logic       accept;
    logic       at_max;

    assign clear_ready_o = (state_q == IDLE) & ~restart_i & ~rst_i;
    assign accept        = clear_valid_i & clear_ready_o;
    assign at_max        = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);

    always_comb begin
        pts = 4'd0;
        case (clear_count_i)
            3'd1:    pts = 4'(PTS_1);
            3'd2:    pts = 4'(PTS_2);
            3'd3:    pts = 4'(PTS_3);
            3'd4:    pts = 4'(PTS_4);
            default: pts = 4'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        add_done_d  = 1'b0;
        bad_count_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (clear_count_i >= 3'd1 && clear_count_i <= 3'd4) begin
                        remaining_d = pts;
                        if (pts != 4'd0) begin
                            state_d = ADD;
                        end else begin
                            add_done_d = 1'b1;
                        end
                    end else begin
                        bad_count_d = 1'b1;
                    end
                end
            end
            ADD: begin
                // Increments past the cap are swallowed but still consume a cycle.
                if (!at_max) begin
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
                remaining_d = remaining_q - 4'd1;
                if (remaining_q == 4'd1) begin
                    state_d    = IDLE;
                    add_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        saturated_d = (tens_d == MAX_TENS) && (ones_d == MAX_ONES);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i) begin
            state_q     <= IDLE;
            remaining_q <= 4'd0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            add_done_q  <= 1'b0;
            bad_count_q <= 1'b0;
            saturated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            add_done_q  <= add_done_d;
            bad_count_q <= bad_count_d;
            saturated_q <= saturated_d;
        end
    end

    assign score_o     = {1'b0, tens_q, 1'b0, ones_q};
    assign add_done_o  = add_done_q;
    assign bad_count_o = bad_count_q;
    assign saturated_o = saturated_q;

endmodule

// File: doc/line_score_bcd_counter.md
Name: line_score_bcd_counter

Overview:
- Upstream feeder of the two-digit score display decoder.
- Accepts line-clear events from the playfield clear logic and converts the number of lines cleared into points.
- Accumulates the points as a two-digit BCD score with saturation.
- Presents the score packed as {tens[4:0], ones[4:0]}, which is the 10-bit format the display stage decodes.
- Addition is serial: one BCD increment per clock, with a valid/ready handshake back to the clear logic.

Parameters:
- PTS_1, default 1: points for a 1-line clear (0..15).
- PTS_2, default 3: points for a 2-line clear (0..15).
- PTS_3, default 5: points for a 3-line clear (0..15).
- PTS_4, default 8: points for a 4-line clear (0..15).
- MAX_SCORE, default 99: saturation value, decimal 1..99.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- restart  input  1  synchronous new-game clear; same effect as rst on score state.
- clear_valid  input  1  line-clear event request.
- clear_count  input  3  lines cleared in the event (valid values 1..4).
- clear_ready  output  1  block can accept an event.
- score  output  10  {tens, ones}; each field is 5 bits with value 0..9, upper 1 bit of each field always 0.
- add_done  output  1  one-cycle pulse when an event's points are fully added.
- saturated  output  1  score has reached MAX_SCORE.
- bad_count  output  1  one-cycle pulse when an event with clear_count 0 or 5..7 is accepted.

Behaviour:
- Reset (rst=1 at edge): score=0, state=IDLE, remaining=0, add_done=0, bad_count=0, saturated=0.
- restart=1 has the same effect as rst. It has priority over any handshake and aborts an in-progress addition.
- clear_ready = (state==IDLE) & ~restart & ~rst. It is a combinational output of registered state.
- Accept: clear_valid & clear_ready at an edge.
  - clear_count 1..4: remaining <= PTS_n.
    - If PTS_n != 0: state <= ADD.
    - If PTS_n == 0: stay IDLE and pulse add_done next cycle.
  - clear_count 0 or 5..7: no score change, stay IDLE, bad_count=1 for exactly the next cycle. No add_done.
- FSM states: IDLE, ADD.
- ADD, every cycle:
  - If score < MAX_SCORE: score <= score+1 in BCD. When ones==9, set ones to 0 and increment tens; otherwise increment ones.
  - If score == MAX_SCORE: score holds.
  - remaining <= remaining-1.
  - When remaining==1 at the edge: state <= IDLE and add_done=1 for the following cycle.
- Latency: an event worth N>0 points holds clear_ready low for exactly N cycles after the accept edge. The final increment and the add_done pulse become visible in the same cycle. A back-to-back event is accepted on the edge that ends the add_done cycle.
- clear_valid while clear_ready=0 is ignored. The producer holds the request until accepted, and the count is sampled only at accept.
- saturated = (score == MAX_SCORE). It is registered and updates in the same cycle as score. It clears only on rst or restart.
- score never exceeds MAX_SCORE. With MAX_SCORE=99, 98+8 yields 99 after the first increment and holds there for the remaining 7 cycles.
- score fields never hold values 10..31. Every register write produces legal BCD.
- All outputs are registered except clear_ready.

Test Plan:
1. rst for 2 cycles, then idle → score=10'b00000_00000, clear_ready=1, add_done=0, saturated=0.
2. Accept clear_count=4 (PTS_4=8) → clear_ready low for 8 cycles. score steps 01..08, one per cycle. add_done pulses in the cycle score=08, and clear_ready returns high that same cycle.
3. Preload to 07 with three 1-line events, then accept clear_count=2 (3 points) → score goes 08, 09, then {1,0} (tens=1, ones=0). Check the BCD carry; no field value of 10 ever appears.
4. Drive to 95, then accept clear_count=4 → score reaches 99 after 4 cycles and holds 4 more. saturated=1 from the cycle score=99. add_done fires after the 8th ADD cycle.
5. Accept clear_count=0 and then clear_count=6 → score unchanged, bad_count pulses once per event, add_done stays 0, clear_ready stays 1.
6. Assert restart in the 3rd cycle of an 8-point add → next cycle score=0 and clear_ready=1, no add_done. Assert restart together with clear_valid in IDLE → event not accepted, score=0.
